shift_sequencer: RTL and testbench

- Upstream control stage for the team's parallel-load/serial-shift register (ports clk, in, shift, D, Q).
- Accepts one command per valid/ready handshake: a parallel word, a fill word and a shift count.
- Drives the register's D/in/shift to load the word, then shifts in up to N fill bits, LSB first.
- Holds the register between commands by reloading its own Q, because the register has no hold mode (shift=0 always loads D).

---
 rtl/shift_sequencer_if.sv | 33 +++
 rtl/shift_sequencer.sv | 108 ++++++++++
 tb/tb_shift_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Command channel between a requester and shift_sequencer.
// Carries one load/fill/shift-count command per handshake.
interface shift_sequencer_if #(
    parameter int N  = 3,
    parameter int CW = 2
) ();
    // Handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both 1. cmd_ready never depends on cmd_valid. The payload
    // (cmd_data, cmd_fill, cmd_shifts) only has to be stable on that edge. When
    // cmd_ready is 0, the receiver ignores cmd_valid and the payload, and
    // nothing is buffered.
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_data;
    logic [N-1:0]  cmd_fill;
    logic [CW-1:0] cmd_shifts;

    modport master (
        output cmd_valid,
        output cmd_data,
        output cmd_fill,
        output cmd_shifts,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  cmd_fill,
        input  cmd_shifts,
        output cmd_ready
    );
endinterface

// File: rtl/shift_sequencer.sv
// Drives a parallel-load/serial-shift register: load a word, shift in up to N
// fill bits LSB first, then hold the register by feeding its own Q back to D.
module shift_sequencer #(
    parameter int N  = 3,
    parameter int CW = 2
) (
    input  logic            clk,
    input  logic            rst,
    shift_sequencer_if.slave cmd,
    input  logic [N-1:0]    q_in,
    output logic [N-1:0]    D,
    output logic            in,
    output logic            shift,
    output logic            busy,
    output logic            done,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CW-1:0] N_CNT   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  data_q,  data_d;
    logic [N-1:0]  fill_q,  fill_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] shifts_clamped;

    assign shifts_clamped = (cmd.cmd_shifts > N_CNT) ? N_CNT : cmd.cmd_shifts;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    data_d  = cmd.cmd_data;
                    fill_d  = cmd.cmd_fill;
                    cnt_d   = shifts_clamped;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                // fill_q[0] is on the serial input this cycle; expose the next bit.
                fill_d = fill_q >> 1;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    // The register has no hold mode, so every non-load cycle reloads its own Q.
    always_comb begin
        D             = q_in;
        in            = 1'b0;
        shift         = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        cmd.cmd_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy          = 1'b0;
                cmd.cmd_ready = 1'b1;
            end
            ST_LOAD: begin
                D = data_q;
            end
            ST_SHIFT: begin
                shift = 1'b1;
                in    = fill_q[0];
            end
            default: begin
                done = 1'b1;
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural register and
// command-level reference model.
module tb_shift_sequencer;

    localparam int N  = 3;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  q_in;
    logic [N-1:0]  d_out;
    logic          in_bit;
    logic          shift;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    logic [N-1:0]  reg_q;
    logic          preload_en;
    logic [N-1:0]  preload_val;

    int checks;
    int errors;
    logic [N-1:0] exp_q[$];

    shift_sequencer_if #(.N(N), .CW(CW)) sif ();

    shift_sequencer #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (sif),
        .q_in      (q_in),
        .D         (d_out),
        .in        (in_bit),
        .shift     (shift),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural parallel-load/serial-shift register
    always @(posedge clk) begin
        if (preload_en)  reg_q <= preload_val;
        else if (shift)  reg_q <= {reg_q[N-2:0], in_bit};
        else             reg_q <= d_out;
    end
    assign q_in = reg_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // register contents after loading data and shifting in n fill bits
    function automatic logic [N-1:0] model_q(input logic [N-1:0] data,
                                             input logic [N-1:0] fill, input int n);
        logic [N-1:0] q;
        q = data;
        for (int i = 0; i < n; i++) q = {q[N-2:0], fill[i]};
        return q;
    endfunction

    function automatic int clamp(input logic [CW-1:0] s);
        return (int'(s) > N) ? N : int'(s);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (sif.cmd_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (sif.cmd_ready !== 1'b1) chk("ready_timeout", 32'(sif.cmd_ready), 1);
    endtask

    // Issue one command at a negedge and check every cycle until back in idle.
    task automatic run_cmd(input logic [N-1:0] data, input logic [N-1:0] fill,
                           input logic [CW-1:0] shifts, input bit keep_valid);
        int k;
        logic exp_shift;
        logic [N-1:0] final_q;
        k = clamp(shifts);
        wait_ready();
        sif.cmd_valid  = 1'b1;
        sif.cmd_data   = data;
        sif.cmd_fill   = fill;
        sif.cmd_shifts = shifts;
        exp_q.push_back(model_q(data, fill, k));
        step();
        for (int c = 1; c <= k + 2; c++) begin
            if (keep_valid) begin
                sif.cmd_data   = N'($urandom);
                sif.cmd_fill   = N'($urandom);
                sif.cmd_shifts = CW'($urandom);
            end else begin
                sif.cmd_valid = 1'b0;
            end
            exp_shift = (c >= 2 && c <= k + 1);
            chk("shift", 32'(shift), 32'(exp_shift));
            chk("busy", 32'(busy), 1);
            chk("ready_busy", 32'(sif.cmd_ready), 0);
            chk("done", 32'(done), 32'(c == k + 2));
            if (c == 1) chk("d_load", 32'(d_out), 32'(data));
            else        chk("d_hold", 32'(d_out), 32'(reg_q));
            if (exp_shift) chk("in_bit", 32'(in_bit), 32'(fill[c-2]));
            else           chk("in_zero", 32'(in_bit), 0);
            if (c >= 2) chk("q_prog", 32'(reg_q), 32'(model_q(data, fill, c - 2)));
            if (c < k + 2) step();
        end
        final_q = exp_q.pop_front();
        chk("result", 32'(reg_q), 32'(final_q));
        step();
        chk("idle_ready", 32'(sif.cmd_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_shift", 32'(shift), 0);
        chk("idle_hold", 32'(reg_q), 32'(final_q));
    endtask

    task automatic reset_mid_shift(input logic [N-1:0] data, input logic [N-1:0] fill);
        logic [N-1:0] frozen;
        wait_ready();
        sif.cmd_valid  = 1'b1;
        sif.cmd_data   = data;
        sif.cmd_fill   = fill;
        sif.cmd_shifts = CW'(3);
        step();
        sif.cmd_valid = 1'b0;
        step();
        step();
        chk("rst_in_shift", 32'(shift), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        frozen = model_q(data, fill, 2);
        chk("rst_state", 32'(dbg_state), 0);
        chk("rst_ready", 32'(sif.cmd_ready), 1);
        chk("rst_q", 32'(reg_q), 32'(frozen));
        for (int i = 0; i < 4; i++) begin
            chk("rst_no_done", 32'(done), 0);
            chk("rst_busy", 32'(busy), 0);
            step();
            chk("rst_frozen", 32'(reg_q), 32'(frozen));
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        preload_en     = 1'b1;
        preload_val    = 3'b110;
        sif.cmd_valid  = 1'b0;
        sif.cmd_data   = '0;
        sif.cmd_fill   = '0;
        sif.cmd_shifts = '0;
        @(negedge clk);
        preload_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // reset then idle hold
        for (int i = 0; i < 5; i++) begin
            chk("rst_ready", 32'(sif.cmd_ready), 1);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_shift", 32'(shift), 0);
            chk("rst_d_track", 32'(d_out), 32'(reg_q));
            chk("rst_hold_q", 32'(reg_q), 32'h6);
            step();
        end

        run_cmd(3'b101, 3'b011, 3'd2, 1'b0);
        run_cmd(3'b010, 3'b111, 3'd0, 1'b0);
        run_cmd(3'b000, 3'b101, 3'd3, 1'b0);
        run_cmd(3'b000, 3'b101, 3'd7, 1'b0);
        run_cmd(3'b110, 3'b001, 3'd2, 1'b1);
        run_cmd(3'b011, 3'b110, 3'd1, 1'b0);
        reset_mid_shift(3'b100, 3'b101);

        for (int i = 0; i < 40; i++) begin
            run_cmd(N'($urandom), N'($urandom), CW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
        end
        sif.cmd_valid = 1'b0;
        step();
        chk("end_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
